priority_arbiter: RTL and testbench

Registered N-way priority arbiter: the sequential successor to the combinational 8-to-3 priority encoder. It samples a request vector, issues a held one-hot grant plus its encoded index, and keeps that grant until the owner finishes, withdraws, or times out. It sits in front of any shared resource (bus, memory port, ALU) that several requesters contend for. Arbitration is fixed-priority (highest index wins); round-robin fairness is an optional compile-time mode.

---
 rtl/priority_arbiter_if.sv | 32 +++
 rtl/priority_arbiter.sv | 116 +++++++++++
 tb/tb_priority_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between requesters and priority_arbiter.
// master = requester side, slave = arbiter side.
interface priority_arbiter_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             busy;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output busy
  );
endinterface

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter with held grant, withdrawal and timeout release.
// Define PRIO_ARB_RR_EN for round-robin priority instead of fixed priority.
module priority_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  priority_arbiter_if.slave    bus
);
  localparam int IDX_W = $clog2(N);
  localparam int HW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    RELEASE
  } state_t;

  state_t           state;
  logic [N-1:0]     grant_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             busy_q;
  logic [HW-1:0]    hold_cnt;
  logic [IDX_W-1:0] win;
  logic             timeout;
  logic             rel_now;

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.busy        = busy_q;

  // grant_q is one-hot, so masking with it clears the owner bit
  assign timeout = (MAX_HOLD != 0)
                && (hold_cnt == HOLD_LAST)
                && (|(bus.req & ~grant_q));
  assign rel_now = bus.done
                || !(|(bus.req & grant_q))
                || timeout;

`ifdef PRIO_ARB_RR_EN
  logic [IDX_W-1:0] last_idx;
  logic             found;
  int               j;

  // search downward from last_idx-1, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_idx) + N - k) % N;
      if (!found && bus.req[j]) begin
        win   = IDX_W'(j);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++)
      if (bus.req[i]) win = IDX_W'(i);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      hold_cnt <= '0;
`ifdef PRIO_ARB_RR_EN
      last_idx <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= OWNED;
            grant_q  <= ONE << win;
            idx_q    <= win;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
`ifdef PRIO_ARB_RR_EN
            last_idx <= win;
`endif
          end
        end
        OWNED: begin
          if (rel_now) begin
            state   <= RELEASE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter (N=8, MAX_HOLD=4).
// Model predicts each cycle's outputs; monitor compares on falling edges.
module tb_priority_arbiter;
  localparam int N        = 8;
  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  priority_arbiter_if #(.N(N)) bus ();

  priority_arbiter #(
    .N(N),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = none), cycles owned so far, release flag
  int owner = -1;
  int age   = 0;
  bit rel   = 1'b0;
  int last  = 0;

  function automatic int pick(input logic [7:0] r);
`ifdef PRIO_ARB_RR_EN
    for (int off = 1; off <= N; off++) begin
      int c = (last + N - off) % N;
      if (r[c]) return c;
    end
    return 0;
`else
    for (int i = N - 1; i >= 0; i--)
      if (r[i]) return i;
    return 0;
`endif
  endfunction

  always @(negedge rst_n) begin
    owner = -1;
    age   = 0;
    rel   = 1'b0;
    last  = 0;
  end

  always @(posedge clk) begin
    exp_t e;
    logic [7:0] r;
    logic [7:0] others;
    r = bus.req;
    if (rst_n) begin
      if (rel) begin
        rel = 1'b0;
      end else if (owner < 0) begin
        if (r != 0) begin
          owner = pick(r);
          last  = owner;
          age   = 1;
        end
      end else begin
        others = r & ~(8'(1) << owner);
        if (bus.done || !r[owner] ||
            (MAX_HOLD != 0 && age >= MAX_HOLD && others != 0)) begin
          owner = -1;
          rel   = 1'b1;
        end else begin
          age++;
        end
      end
    end
    e.valid = (owner >= 0);
    e.idx   = (owner >= 0) ? 3'(owner) : 3'd0;
    e.grant = (owner >= 0) ? (8'(1) << owner) : 8'd0;
    e.busy  = (owner >= 0) || rel;
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_grant", bus.grant, e.grant);
      chk("sb_idx", bus.grant_idx, e.idx);
      chk("sb_valid", bus.grant_valid, e.valid);
      chk("sb_busy", bus.busy, e.busy);
    end
  end

  task automatic cyc(input logic [7:0] r, input logic d);
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic look(input string name, input int idx, input bit v);
    chk({name, "_idx"}, bus.grant_idx, idx);
    chk({name, "_valid"}, bus.grant_valid, v);
  endtask

  task automatic rst_checks();
    chk("rst_grant", bus.grant, 0);
    chk("rst_idx", bus.grant_idx, 0);
    chk("rst_valid", bus.grant_valid, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  // reset between edges, leave req = r so the next edge arbitrates it
  task automatic reset_dut(input logic [7:0] r);
    @(negedge clk);
    bus.req  = r;
    bus.done = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_checks();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    logic       d;
    int         e;
    bus.req  = '0;
    bus.done = 1'b0;
    repeat (3) @(negedge clk);
    rst_checks();
    #2 rst_n = 1'b1;

    // reset in the middle of a grant
    reset_dut(8'h80);
    cyc(8'h80, 1'b0);
    look("mg_pre", 7, 1'b1);
    #2 rst_n = 1'b0;
    #1 rst_checks();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    look("mg_post", 7, 1'b1);

    // fixed priority, done release, gap, next winner
    reset_dut(8'h14);
    cyc(8'h14, 1'b1);
    look("fp_a", 4, 1'b1);
    cyc(8'h04, 1'b0);
    look("fp_rel", 0, 1'b0);
    chk("fp_rel_busy", bus.busy, 1);
    cyc(8'h04, 1'b0);
    look("fp_gap", 0, 1'b0);
    cyc(8'h04, 1'b0);
    look("fp_b", 2, 1'b1);

    // withdrawal then idle
    reset_dut(8'h14);
    cyc(8'h00, 1'b0);
    look("wd_a", 4, 1'b1);
    cyc(8'h00, 1'b0);
    look("wd_rel", 0, 1'b0);
    repeat (3) begin
      cyc(8'h00, 1'b0);
      look("wd_idle", 0, 1'b0);
    end

    // timeout with a competitor
    reset_dut(8'h81);
    repeat (MAX_HOLD) begin
      cyc(8'h81, 1'b0);
      look("to_hold", 7, 1'b1);
    end
    cyc(8'h81, 1'b0);
    look("to_rel", 0, 1'b0);
    cyc(8'h81, 1'b0);
    look("to_gap", 0, 1'b0);
    cyc(8'h81, 1'b0);
`ifdef PRIO_ARB_RR_EN
    look("to_next", 0, 1'b1);
`else
    look("to_next", 7, 1'b1);
`endif

    // no competitor: grant never times out
    reset_dut(8'h80);
    repeat (25) begin
      cyc(8'h80, 1'b0);
      look("solo", 7, 1'b1);
    end

    // done and timeout on the same edge
    reset_dut(8'h81);
    repeat (3) cyc(8'h81, 1'b0);
    cyc(8'h81, 1'b1);
    look("sim_last", 7, 1'b1);
    cyc(8'h81, 1'b0);
    look("sim_rel", 0, 1'b0);
    chk("sim_rel_busy", bus.busy, 1);
    cyc(8'h81, 1'b0);
    look("sim_gap", 0, 1'b0);
    chk("sim_gap_busy", bus.busy, 0);
    cyc(8'h81, 1'b0);
    chk("sim_regrant", bus.grant_valid, 1);

    // sweep with all requesters active
    reset_dut(8'hFF);
    for (int k = 0; k < 9; k++) begin
`ifdef PRIO_ARB_RR_EN
      e = (7 - k + N) % N;
`else
      e = 7;
`endif
      cyc(8'hFF, 1'b1);
      look("sweep", e, 1'b1);
      cyc(8'hFF, 1'b0);
      cyc(8'hFF, 1'b0);
    end

    // randomized traffic, checked by the scoreboard
    reset_dut(8'h00);
    r = 8'h00;
    repeat (500) begin
      if ($urandom_range(0, 9) < 3) begin
        r = 8'($urandom);
        if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
        if ($urandom_range(0, 7) == 0) r = 8'h00;
      end
      d = ($urandom_range(0, 5) == 0);
      cyc(r, d);
    end
    cyc(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
